// File: rtl/forward_sub4x4.sv
// -----------------------------------------------------------------------------
// forward_sub4x4
// Sequential 4x4 forward-substitution stage: solves L*y = b for y, with L
// lower-triangular. One multiply-accumulate per cycle. Each row is finished
// by a combinational signed divide, or by a plain copy when the diagonal is
// unit. y_out feeds the backward-substitution stage's y_in unchanged.
//
// Parameters
//   DW         element width in bits (signed two's complement)
//   UNIT_DIAG  1 = diagonal of L is ignored (treated as 1), 0 = divide by L[i][i]
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   one-cycle solve request, sampled only in IDLE
//   L_in   in   16*DW, L[r][c] at DW*(4r+c) +: DW; upper triangle ignored
//   b_in   in   4*DW, b[i] at DW*i +: DW
//   y_out  out  4*DW, y[i] at DW*i +: DW; updated only at completion
//   done   out  one-cycle pulse when y_out holds a new result
//   busy   out  high while a solve is in progress
//   err    out  divide-by-zero seen in this solve; held until next start
// -----------------------------------------------------------------------------
module forward_sub4x4 #(
    parameter int DW        = 32,
    parameter bit UNIT_DIAG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [16*DW-1:0] L_in,
    input  logic [4*DW-1:0]  b_in,
    output logic [4*DW-1:0]  y_out,
    output logic            done,
    output logic            busy,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [DW-1:0] l_reg [4][4];
    logic [DW-1:0] b_reg [4];
    logic [DW-1:0] y_int [4];
    logic [DW-1:0] acc;
    logic [1:0]    row;
    logic [1:0]    col;

    logic [DW-1:0] prod;
    logic [DW-1:0] diag;
    logic [DW-1:0] divisor;
    logic [DW-1:0] quot;
    logic [DW-1:0] y_val;
    logic          diag_zero;

    // Only the low DW bits of the product matter: acc wraps on overflow, and
    // the low half of a product is the same for signed and unsigned operands.
    assign prod = l_reg[row][col] * y_int[col];

    // The divisor is forced to 1 on a zero diagonal so the divider never sees
    // a zero. The quotient is discarded in that case anyway.
    assign diag      = l_reg[row][row];
    assign diag_zero = !UNIT_DIAG && (diag == '0);
    assign divisor   = (diag == '0) ? DW'(1) : diag;
    assign quot      = $signed(acc) / $signed(divisor);
    assign y_val     = UNIT_DIAG ? acc : (diag_zero ? '0 : quot);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Row 0 has nothing to accumulate, so a start goes
    // straight to FIN. Row i spends i cycles in MAC, with columns 0..i-1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = FIN;
            MAC:  if (col == row - 2'd1) state_next = FIN;
            FIN:  state_next = (row == 2'd3) ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. y_out is written only at the last FIN, so it never shows a
    // partially solved vector. The last element goes straight from y_val
    // because y_int[3] is not written until the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    l_reg[r][c] <= '0;
                end
                b_reg[r] <= '0;
                y_int[r] <= '0;
            end
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            y_out <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < 4; r++) begin
                            for (int c = 0; c < 4; c++) begin
                                l_reg[r][c] <= L_in[DW*(4*r+c) +: DW];
                            end
                            b_reg[r] <= b_in[DW*r +: DW];
                        end
                        acc  <= b_in[0 +: DW];
                        row  <= '0;
                        col  <= '0;
                        busy <= 1'b1;
                        err  <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc - prod;
                    col <= col + 2'd1;
                end
                FIN: begin
                    y_int[row] <= y_val;
                    if (diag_zero) begin
                        err <= 1'b1;
                    end
                    if (row != 2'd3) begin
                        row <= row + 2'd1;
                        col <= '0;
                        acc <= b_reg[row + 2'd1];
                    end else begin
                        y_out <= {y_val, y_int[2], y_int[1], y_int[0]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/forward_sub4x4.md
Name: forward_sub4x4

Overview:
Sequential 4x4 forward-substitution stage. It solves L·y = b for y, where L is lower-triangular. It sits directly upstream of the 4x4 backward-substitution stage in the matrix-inversion datapath. Its y_out feeds that stage's y_in unchanged, in the same 32-bit-per-element packed format.

Parameters:
DW, 32, element width in bits; signed two's complement integers.
UNIT_DIAG, 1, 1 = L has a unit diagonal (Doolittle LU), so diagonal entries are ignored and no divide occurs; 0 = divide by L[i][i].

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
L_in  input  16*DW  row-major packing: L[r][c] at bits DW*(4r+c) +: DW; entries with c>r are ignored
b_in  input  4*DW  b[i] at bits DW*i +: DW
y_out  output  4*DW  result; y[i] at bits DW*i +: DW
done  output  1  one-cycle pulse when y_out is valid
busy  output  1  high while a solve is in progress
err  output  1  divide-by-zero flag; valid with done; held until next start

Behaviour:
- Reset, applied at any edge including mid-operation:
  - state goes to IDLE
  - y_out, done, busy, err, all internal registers = 0
  - any in-flight solve is abandoned
- States: IDLE, MAC, FIN.
- IDLE, start=1 (at edge E0):
  - latch L_in and b_in
  - set i=0, j=0, acc=b[0], busy=1, err=0
  - go to FIN, because row 0 needs no MAC
- MAC, one product per cycle:
  - acc <= acc − L[i][j]·y_int[j], taking the low DW bits of the product and wrapping on overflow
  - j++
  - when j reaches i−1, next state is FIN
- FIN:
  - y_int[i] = acc when UNIT_DIAG=1
  - otherwise y_int[i] = acc / L[i][i], signed and truncated toward zero
  - if L[i][i]==0 (only when UNIT_DIAG=0): y_int[i]=0, err<=1 (sticky for this solve), and processing continues
  - if i<3: i++, j=0, acc=b[i+1], go to MAC
  - if i==3: go to the completion step below
- Completion edge (FIN with i==3):
  - y_out <= y_int with y[3] included
  - done <= 1, busy <= 0, go to IDLE
- Schedule: row i costs i MAC cycles + 1 FIN cycle.
- Latency: done is high in the cycle following edge E10, i.e. 10 clocks after start was sampled.
- done: exactly one cycle wide.
- y_out:
  - changes only at the completion edge
  - holds until the next completion or reset
  - never shows partial results
- start while busy=1: ignored; no restart, no effect on the result.
- start in the cycle where done=1:
  - state is already IDLE, so it is accepted and a new solve begins
  - y_out keeps the previous result until the new completion
- L_in and b_in are don't-care after E0; changes during busy do not affect the result.
- Division uses a combinational DW-bit signed divider in the FIN cycle; no multi-cycle divide.

Test Plan:
1. Unit diagonal (UNIT_DIAG=1). L=[[1,0,0,0],[2,1,0,0],[3,4,1,0],[1,2,3,1]], b=(1,4,14,18), one-cycle start → done pulses 10 clocks after start; y_out=(1,2,3,4); err=0; busy high for exactly 10 cycles. Then feed y_out into the backward stage as its y_in and check the chained x.
2. Non-unit diagonal (UNIT_DIAG=0). L=[[2,0,0,0],[1,3,0,0],[0,2,4,0],[1,1,1,5]], b=(6,6,10,1) → y_out=(3,1,2,−1), err=0. Junk in the upper-triangle entries must not change the result.
3. Truncation and sign (UNIT_DIAG=0, L=diag(2,2,2,2), off-diagonals 0). b=(7,−7,1,−1) → y_out=(3,−3,0,0).
4. Divide by zero (UNIT_DIAG=0). Case 2 with L[1][1]=0 → y[1]=0, err=1 at done, done still at 10 clocks. The next clean solve returns err=0.
5. Control hazards:
   - start re-asserted at cycles 3 and 7 of a solve → single done at 10, result unchanged
   - L_in/b_in scrambled after E0 → result unchanged
   - start in the done cycle → second solve completes 10 clocks later
6. Reset mid-operation: rst=1 for one cycle at cycle 5 → busy=0, done never pulses, y_out=0. A fresh start afterwards yields the correct result.
